// File: rtl/fazyrv_rf_chunked_if.sv
// Operand fetch / result write-back bus between the FazyRV core and its chunk-serial RF.
// The RF uses the slave modport; the core (or a bench) drives the master modport.
interface fazyrv_rf_chunked_if #(
  parameter int unsigned CHUNKSIZE = 8
);
  logic                 rstb_i;
  logic [4:0]           rs1_i;
  logic [4:0]           rs2_i;
  logic                 rdy_o;
  logic                 busy_o;
  logic                 shft_i;
  logic [CHUNKSIZE-1:0] ra_o;
  logic [CHUNKSIZE-1:0] rb_o;
  logic [CHUNKSIZE-1:0] res_i;
  logic [4:0]           rd_i;
  logic                 we_i;
  logic                 wstb_i;
  logic                 err_o;

  modport slave (
    input  rstb_i, rs1_i, rs2_i, shft_i, res_i, rd_i, we_i, wstb_i,
    output rdy_o, busy_o, ra_o, rb_o, err_o
  );

  modport master (
    output rstb_i, rs1_i, rs2_i, shft_i, res_i, rd_i, we_i, wstb_i,
    input  rdy_o, busy_o, ra_o, rb_o, err_o
  );
endinterface

// File: rtl/fazyrv_rf_chunked.sv
// Chunk-serial register file: fetches two operands, streams them LSB-first in CHUNKSIZE
// slices and commits a shifted-in result word. FAZYRV_RF_BYPASS_EN forwards same-cycle commits.
module fazyrv_rf_chunked #(
  parameter int unsigned CHUNKSIZE = 8,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned DUALRD    = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fazyrv_rf_chunked_if.slave bus
);

  localparam int unsigned NSHIFT = 32 / CHUNKSIZE;
  localparam int unsigned CW     = $clog2(NSHIFT) + 1;
  localparam int unsigned AW     = $clog2(NREGS);
  localparam logic        RV32E  = (NREGS == 16);

  typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_B, LOAD, SHIFT} state_e;

  // Bit 4 of an index is only meaningful with a 32-deep file.
  function automatic logic legal(input logic [4:0] idx);
    return !(RV32E && idx[4]);
  endfunction

  logic [31:0]          mem_q [NREGS];
  state_e               state_q, state_d;
  logic [4:0]           rs2_q, rs2_d;
  logic [31:0]          opa_q, opa_d, opb_q, opb_d;
  logic [31:0]          sra_q, sra_d, srb_q, srb_d;
  logic [31:0]          wb_q, wb_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 rdy_q, rdy_d, busy_q, busy_d, err_q, err_d;
  logic [CHUNKSIZE-1:0] ra_q, ra_d, rb_q, rb_d;

  logic                 commit_c, accept_c;
  logic [4:0]           rb_idx_c;
  logic [31:0]          rda_c, rdb_c;

  assign commit_c = bus.wstb_i && bus.we_i && (bus.rd_i != 5'd0) && legal(bus.rd_i) && !rst_i;
  assign accept_c = (state_q == IDLE) && bus.rstb_i;
  assign rb_idx_c = (DUALRD != 0) ? bus.rs2_i : rs2_q;

  // Port A is read on the strobe edge; port B with it (dual) or one cycle later (single).
  always_comb begin
    rda_c = '0;
    if ((bus.rs1_i != 5'd0) && legal(bus.rs1_i)) rda_c = mem_q[bus.rs1_i[AW-1:0]];
`ifdef FAZYRV_RF_BYPASS_EN
    if (commit_c && (bus.rs1_i == bus.rd_i)) rda_c = wb_q;
`endif
  end

  always_comb begin
    rdb_c = '0;
    if ((rb_idx_c != 5'd0) && legal(rb_idx_c)) rdb_c = mem_q[rb_idx_c[AW-1:0]];
`ifdef FAZYRV_RF_BYPASS_EN
    if (commit_c && (rb_idx_c == bus.rd_i)) rdb_c = wb_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    rs2_d   = rs2_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sra_d   = sra_q;
    srb_d   = srb_q;
    cnt_d   = cnt_q;
    wb_d    = bus.shft_i ? {bus.res_i, wb_q[31:CHUNKSIZE]} : wb_q;
    err_d   = (accept_c && (!legal(bus.rs1_i) || !legal(bus.rs2_i)))
           || (bus.wstb_i && !legal(bus.rd_i));

    case (state_q)
      IDLE: begin
        if (bus.rstb_i) begin
          rs2_d   = bus.rs2_i;
          opa_d   = rda_c;
          if (DUALRD != 0) opb_d = rdb_c;
          state_d = FETCH_A;
        end
      end
      FETCH_A: begin
        if (DUALRD != 0) begin
          state_d = LOAD;
        end else begin
          opb_d   = rdb_c;
          state_d = FETCH_B;
        end
      end
      FETCH_B: state_d = LOAD;
      LOAD: begin
        sra_d   = opa_q;
        srb_d   = opb_q;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (bus.shft_i) begin
          sra_d = sra_q >> CHUNKSIZE;
          srb_d = srb_q >> CHUNKSIZE;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(NSHIFT - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rdy_d  = (state_d == SHIFT);
    busy_d = (state_d == FETCH_A) || (state_d == FETCH_B) || (state_d == LOAD);
    ra_d   = (state_d == SHIFT) ? sra_d[CHUNKSIZE-1:0] : '0;
    rb_d   = (state_d == SHIFT) ? srb_d[CHUNKSIZE-1:0] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rs2_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sra_q   <= '0;
      srb_q   <= '0;
      wb_q    <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ra_q    <= '0;
      rb_q    <= '0;
    end else begin
      state_q <= state_d;
      rs2_q   <= rs2_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sra_q   <= sra_d;
      srb_q   <= srb_d;
      wb_q    <= wb_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
    end
  end

  // Storage is never reset; a commit during reset is already masked in commit_c.
  always_ff @(posedge clk_i) begin
    if (commit_c) mem_q[bus.rd_i[AW-1:0]] <= wb_q;
  end

  assign bus.rdy_o  = rdy_q;
  assign bus.busy_o = busy_q;
  assign bus.err_o  = err_q;
  assign bus.ra_o   = ra_q;
  assign bus.rb_o   = rb_q;

endmodule
